// File: rtl/wb_forward_history_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_forward_history_if
//  Description : Signal bundle between the writeback stage/consumers and the
//                writeback forwarding history buffer.
//                master : drives rd_w, reg_write_w, result_w, stall, flush,
//                         lookup_rs; receives fwd_hit, fwd_data, rd_b,
//                         reg_write_b, result_b, count.
//                slave  : the history buffer itself (directions reversed).
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_forward_history_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 2,
   parameter int NUM_LOOKUP = 2
);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic [REG_ADDR_W-1:0]            rd_w;
   logic                             reg_write_w;
   logic [XLEN-1:0]                  result_w;
   logic                             stall;
   logic                             flush;
   logic [NUM_LOOKUP*REG_ADDR_W-1:0] lookup_rs;
   logic [NUM_LOOKUP-1:0]            fwd_hit;
   logic [NUM_LOOKUP*XLEN-1:0]       fwd_data;
   logic [REG_ADDR_W-1:0]            rd_b;
   logic                             reg_write_b;
   logic [XLEN-1:0]                  result_b;
   logic [c_CNT_W-1:0]               count;

   modport master (
      output rd_w, reg_write_w, result_w, stall, flush, lookup_rs,
      input  fwd_hit, fwd_data, rd_b, reg_write_b, result_b, count
   );

   modport slave (
      input  rd_w, reg_write_w, result_w, stall, flush, lookup_rs,
      output fwd_hit, fwd_data, rd_b, reg_write_b, result_b, count
   );
endinterface
`default_nettype wire

// File: rtl/wb_forward_history.sv
`default_nettype none
// ============================================================================
//  Module      : wb_forward_history
//  Description : Shift register of the last DEPTH retired writebacks with
//                combinational forwarding lookup. Entry 0 is the youngest and
//                doubles as a one-cycle-delayed writeback (rd_b/reg_write_b/
//                result_b). Edge priority: rst > flush > stall > shift.
//  Ports       : clk, rst (sync, active-high)
//                bus.slave : rd_w/reg_write_w/result_w retiring write,
//                            stall/flush control, lookup_rs packed indices,
//                            fwd_hit/fwd_data packed lookup results,
//                            rd_b/reg_write_b/result_b entry 0, count.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_forward_history #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 2,
   parameter int NUM_LOOKUP = 2
) (
   input  wire                   clk,
   input  wire                   rst,
   wb_forward_history_if.slave   bus
);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]            r_valid;
   logic [REG_ADDR_W-1:0]       r_rd   [DEPTH];
   logic [XLEN-1:0]             r_data [DEPTH];
   logic [c_CNT_W-1:0]          r_count;

   logic [DEPTH-1:0]            w_valid_nxt;
   logic [c_CNT_W-1:0]          w_count_nxt;
   logic                        w_shift;
   logic [NUM_LOOKUP-1:0]       w_hit;
   logic [NUM_LOOKUP*XLEN-1:0]  w_data;

   // Fields only move on a real shift; flush clears valid bits but keeps
   // rd/data so the delayed-writeback view stays stable.
   assign w_shift = !bus.flush && !bus.stall;

   // Next valid vector and its population; count is registered from this so
   // it always equals the valid-bit population after the edge.
   always_comb begin
      w_valid_nxt = r_valid;
      if (bus.flush) begin
         w_valid_nxt = '0;
      end else if (!bus.stall) begin
         for (int i = 1; i < DEPTH; i++) begin
            w_valid_nxt[i] = r_valid[i-1];
         end
         // x0 writes and non-writes enter as bubbles
         w_valid_nxt[0] = bus.reg_write_w && (bus.rd_w != '0);
      end
      w_count_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_count_nxt = w_count_nxt + c_CNT_W'(w_valid_nxt[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]   <= '0;
            r_data[i] <= '0;
         end
      end else begin
         r_valid <= w_valid_nxt;
         r_count <= w_count_nxt;
         if (w_shift) begin
            for (int i = 1; i < DEPTH; i++) begin
               r_rd[i]   <= r_rd[i-1];
               r_data[i] <= r_data[i-1];
            end
            r_rd[0]   <= bus.rd_w;
            r_data[0] <= bus.result_w;
         end
      end
   end

   // Lookup reads registered state only. Scanning oldest to youngest lets
   // the youngest match overwrite older ones.
   always_comb begin
      w_hit  = '0;
      w_data = '0;
      for (int k = 0; k < NUM_LOOKUP; k++) begin
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] &&
                (bus.lookup_rs[k*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                (r_rd[i] == bus.lookup_rs[k*REG_ADDR_W +: REG_ADDR_W])) begin
               w_hit[k]                = 1'b1;
               w_data[k*XLEN +: XLEN]  = r_data[i];
            end
         end
      end
   end

   assign bus.fwd_hit     = w_hit;
   assign bus.fwd_data    = w_data;
   assign bus.rd_b        = r_rd[0];
   assign bus.reg_write_b = r_valid[0];
   assign bus.result_b    = r_data[0];
   assign bus.count       = r_count;

endmodule
`default_nettype wire

// File: doc/wb_forward_history.md
WB_FORWARD_HISTORY -- requirements
Module: wb_forward_history

Interface
REQ-001 Parameter XLEN, 32, width of the result datapath.
REQ-002 Parameter REG_ADDR_W, 5, register-index width.
REQ-003 Parameter DEPTH, 2, number of retained writeback entries (legal 1..8).
REQ-004 Parameter NUM_LOOKUP, 2, number of independent forwarding lookup ports (legal 1..4).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rd_w  input  REG_ADDR_W  destination register of the retiring instruction.
REQ-008 reg_write_w  input  1  retiring instruction writes rd_w.
REQ-009 result_w  input  XLEN  value written to rd_w.
REQ-010 stall  input  1  hold all entries this cycle.
REQ-011 flush  input  1  invalidate all entries this cycle.
REQ-012 lookup_rs  input  NUM_LOOKUP*REG_ADDR_W  packed source-register indices; port k at bits [k*REG_ADDR_W +: REG_ADDR_W].
REQ-013 fwd_hit  output  NUM_LOOKUP  port k matched a valid entry.
REQ-014 fwd_data  output  NUM_LOOKUP*XLEN  packed forwarded values, port k at [k*XLEN +: XLEN].
REQ-015 rd_b  output  REG_ADDR_W  entry 0 destination (one-stage-delayed writeback, drop-in compatible).
REQ-016 reg_write_b  output  1  entry 0 valid.
REQ-017 result_b  output  XLEN  entry 0 value.
REQ-018 count  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-019 State SHALL be DEPTH entries {valid, rd, data}; entry 0 youngest, entry DEPTH-1 oldest.
REQ-020 Priority per edge SHALL be rst > flush > stall > shift.
REQ-021 Shift: entry[i] <= entry[i-1] for i>=1; entry 0 <= {reg_write_w && rd_w!=0, rd_w, result_w}; oldest entry discarded.
REQ-022 An input with reg_write_w=0 or rd_w=0 SHALL still shift in, as an invalid entry (bubble); rd and data captured unchanged.
REQ-023 Stall: all entries and count SHALL hold; inputs ignored.
REQ-024 Flush: all valid bits SHALL clear and count SHALL become 0; rd/data fields hold; flush with stall behaves as flush.
REQ-025 Latency: input to rd_b/reg_write_b/result_b SHALL be exactly 1 cycle when not stalled.
REQ-026 count SHALL be a register equal to the population of valid bits after each edge; it never exceeds DEPTH.
REQ-027 Lookup SHALL be combinational from registered state only (no input-to-output path from rd_w/result_w).
REQ-028 fwd_hit[k]=1 iff lookup_rs port k != 0 and some valid entry has rd equal to it.
REQ-029 On multiple matches fwd_data port k SHALL take the youngest (lowest-index) matching entry.
REQ-030 On miss fwd_data port k SHALL be 0.
REQ-031 All lookup ports SHALL evaluate independently and simultaneously; identical indices give identical results.
REQ-032 DEPTH=1 SHALL reduce to a single pipeline register plus lookup.

Reset
REQ-033 While rst=1 at an edge, every entry SHALL clear to {0,0,0} and count to 0, regardless of stall/flush.
REQ-034 After reset: rd_b=0, reg_write_b=0, result_b=0, count=0, fwd_hit=0, fwd_data=0.
REQ-035 Reset asserted mid-operation SHALL discard all entries on that edge; first post-reset edge with valid input loads entry 0 normally.

Verification
REQ-036 DEPTH=2: push (x5,0xAAAA_0001) then (x6,0x0000_0002) -> count=2; lookup x5 hit data 0xAAAA_0001; lookup x6 hit 0x0000_0002; rd_b=6.
REQ-037 Push (x5,0x11) then (x5,0x22) -> lookup x5 returns 0x22 (youngest wins); third push (x7,0x33) -> x5 still hits 0x22, count=2.
REQ-038 Push rd_w=0, reg_write_w=1, 0xFFFF_FFFF -> reg_write_b=0, lookup x0 fwd_hit=0, fwd_data=0.
REQ-039 Entries loaded, stall=1 for 3 cycles with changing inputs -> outputs and count unchanged; stall=1 and flush=1 together -> count=0, all hits 0.
REQ-040 rst=1 with stall=1 and entries valid -> next cycle all outputs 0; deassert, push (x3,0x5) -> reg_write_b=1, rd_b=3 one cycle later.
REQ-041 NUM_LOOKUP=2 with ports set to x5 and x9, only x5 valid -> fwd_hit=2'b01, port 1 data 0.
